// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the traffic-light controller and its sensors, walk latch and interval timer.
// The slave side is the controller; the master side is the surrounding logic or a bench.
interface traffic_light_fsm_if;
  logic       Sensor_Sync;
  logic       WR;
  logic       Prog_Sync;
  logic       expired;
  logic       WR_Reset;
  logic [1:0] interval;
  logic       start_timer;
  logic [6:0] LEDs;

  modport master (
    output Sensor_Sync, WR, Prog_Sync, expired,
    input  WR_Reset, interval, start_timer, LEDs
  );

  modport slave (
    input  Sensor_Sync, WR, Prog_Sync, expired,
    output WR_Reset, interval, start_timer, LEDs
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Main/side-street traffic-light Moore FSM with walk phase; TRAFFIC_SIDE_EXT_EN adds side-green extension S5.
// Outputs registered one cycle after the deciding edge; no backpressure, expired is ignored while start_timer=1.
module traffic_light_fsm #(
  parameter logic [1:0] T_BASE = 2'b00,
  parameter logic [1:0] T_EXT  = 2'b01,
  parameter logic [1:0] T_YEL  = 2'b10
) (
  input  logic                 clk,
  input  logic                 Reset,
  traffic_light_fsm_if.slave   bus
);

  typedef enum logic [2:0] {
    S0_MAIN_GRN_BASE = 3'd0,
    S1_MAIN_GRN_2    = 3'd1,
    S2_MAIN_YEL      = 3'd2,
    S3_WALK          = 3'd3,
    S4_SIDE_GRN_BASE = 3'd4,
    S5_SIDE_GRN_EXT  = 3'd5,
    S6_SIDE_YEL      = 3'd6
  } state_t;

  // LED order: main R/Y/G, side R/Y/G, walk
  localparam logic [6:0] LED_MAIN_GRN = 7'b0011000;
  localparam logic [6:0] LED_MAIN_YEL = 7'b0101000;
  localparam logic [6:0] LED_WALK     = 7'b1001001;
  localparam logic [6:0] LED_SIDE_GRN = 7'b1000010;
  localparam logic [6:0] LED_SIDE_YEL = 7'b1000100;

  state_t     state;
  state_t     state_nxt;
  logic       advance;
  logic [1:0] interval_nxt;
  logic [6:0] leds_nxt;
  logic       wr_reset_nxt;
  logic       start_nxt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state           <= S0_MAIN_GRN_BASE;
      bus.interval    <= T_BASE;
      bus.LEDs        <= LED_MAIN_GRN;
      bus.WR_Reset    <= 1'b0;
      bus.start_timer <= 1'b1;
    end else begin
      state           <= state_nxt;
      bus.interval    <= interval_nxt;
      bus.LEDs        <= leds_nxt;
      bus.WR_Reset    <= wr_reset_nxt;
      bus.start_timer <= start_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    interval_nxt = bus.interval;
    leds_nxt     = bus.LEDs;
    wr_reset_nxt = bus.WR_Reset;
    start_nxt    = 1'b0;
    // An expiry landing on the restart cycle belongs to the previous interval.
    advance      = bus.expired && !bus.start_timer;

    case (state)
      S0_MAIN_GRN_BASE: if (advance) state_nxt = S1_MAIN_GRN_2;
      S1_MAIN_GRN_2:    if (advance) state_nxt = S2_MAIN_YEL;
      S2_MAIN_YEL:      if (advance) state_nxt = bus.WR ? S3_WALK : S4_SIDE_GRN_BASE;
      S3_WALK:          if (advance) state_nxt = S4_SIDE_GRN_BASE;
`ifdef TRAFFIC_SIDE_EXT_EN
      S4_SIDE_GRN_BASE: if (advance) state_nxt = bus.Sensor_Sync ? S5_SIDE_GRN_EXT : S6_SIDE_YEL;
      S5_SIDE_GRN_EXT:  if (advance) state_nxt = S6_SIDE_YEL;
`else
      S4_SIDE_GRN_BASE: if (advance) state_nxt = S6_SIDE_YEL;
`endif
      S6_SIDE_YEL:      if (advance) state_nxt = S0_MAIN_GRN_BASE;
      default:          state_nxt = S0_MAIN_GRN_BASE;
    endcase

    if (bus.Prog_Sync) state_nxt = S0_MAIN_GRN_BASE;

    // Outputs only change on entry to a state, so S1 keeps the interval chosen at entry.
    if (bus.Prog_Sync || (state_nxt != state)) begin
      start_nxt    = 1'b1;
      wr_reset_nxt = 1'b0;
      case (state_nxt)
        S0_MAIN_GRN_BASE: begin
          interval_nxt = T_BASE;
          leds_nxt     = LED_MAIN_GRN;
        end
        S1_MAIN_GRN_2: begin
          interval_nxt = bus.Sensor_Sync ? T_EXT : T_BASE;
          leds_nxt     = LED_MAIN_GRN;
        end
        S2_MAIN_YEL: begin
          interval_nxt = T_YEL;
          leds_nxt     = LED_MAIN_YEL;
        end
        S3_WALK: begin
          interval_nxt = T_EXT;
          leds_nxt     = LED_WALK;
          wr_reset_nxt = 1'b1;
        end
        S4_SIDE_GRN_BASE: begin
          interval_nxt = T_BASE;
          leds_nxt     = LED_SIDE_GRN;
        end
`ifdef TRAFFIC_SIDE_EXT_EN
        S5_SIDE_GRN_EXT: begin
          interval_nxt = T_EXT;
          leds_nxt     = LED_SIDE_GRN;
        end
`endif
        S6_SIDE_YEL: begin
          interval_nxt = T_YEL;
          leds_nxt     = LED_SIDE_YEL;
        end
        default: begin
          interval_nxt = T_BASE;
          leds_nxt     = LED_MAIN_GRN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm; expected outputs are hand-computed per state.
module tb_traffic_light_fsm;
  logic clk = 1'b0;
  logic Reset;

  traffic_light_fsm_if tif ();

  traffic_light_fsm dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (tif)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] L_MG = 7'b0011000;
  localparam logic [6:0] L_MY = 7'b0101000;
  localparam logic [6:0] L_WK = 7'b1001001;
  localparam logic [6:0] L_SG = 7'b1000010;
  localparam logic [6:0] L_SY = 7'b1000100;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] leds, input logic [1:0] iv,
                         input logic wrr, input logic st);
    chk({tag, ".leds"},  32'(tif.LEDs),        32'(leds));
    chk({tag, ".intv"},  32'(tif.interval),    32'(iv));
    chk({tag, ".wrrst"}, 32'(tif.WR_Reset),    32'(wrr));
    chk({tag, ".start"}, 32'(tif.start_timer), 32'(st));
  endtask

  // One expiry pulse, then the entry cycle and the first settled cycle of the new state.
  task automatic step(input string tag, input logic [6:0] leds, input logic [1:0] iv, input logic wrr);
    tif.expired = 1'b1;
    tick();
    tif.expired = 1'b0;
    chk_out(tag, leds, iv, wrr, 1'b1);
    tick();
    chk_out({tag, ".hold"}, leds, iv, wrr, 1'b0);
  endtask

  initial begin
    Reset           = 1'b1;
    tif.Sensor_Sync = 1'b0;
    tif.WR          = 1'b0;
    tif.Prog_Sync   = 1'b0;
    tif.expired     = 1'b0;
    tick();
    chk_out("rst_held", L_MG, 2'b00, 1'b0, 1'b1);
    tick();
    chk_out("rst_held2", L_MG, 2'b00, 1'b0, 1'b1);
    Reset = 1'b0;
    tick();
    chk_out("rst_rel", L_MG, 2'b00, 1'b0, 1'b0);

    // Full cycle with a walk request and no side traffic
    tif.WR = 1'b1;
    step("a_s1", L_MG, 2'b00, 1'b0);
    step("a_s2", L_MY, 2'b10, 1'b0);
    step("a_s3", L_WK, 2'b01, 1'b1);
    step("a_s4", L_SG, 2'b00, 1'b0);
    step("a_s6", L_SY, 2'b10, 1'b0);
    step("a_s0", L_MG, 2'b00, 1'b0);

    // Side traffic present, no walk
    tif.WR          = 1'b0;
    tif.Sensor_Sync = 1'b1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    step("b_s1", L_MG, 2'b01, 1'b0);
    step("b_s2", L_MY, 2'b10, 1'b0);
    step("b_s4", L_SG, 2'b00, 1'b0);
`ifdef TRAFFIC_SIDE_EXT_EN
    step("b_s5", L_SG, 2'b01, 1'b0);
`endif
    step("b_s6", L_SY, 2'b10, 1'b0);
    step("b_s0", L_MG, 2'b00, 1'b0);

    // Expiry overlapping the start pulse, then held two cycles
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tif.expired = 1'b1;
    tick();
    chk_out("c_ign", L_MG, 2'b00, 1'b0, 1'b0);
    tick();
    chk_out("c_s1", L_MG, 2'b01, 1'b0, 1'b1);
    tif.expired = 1'b0;
    tick();
    chk_out("c_s1hold", L_MG, 2'b01, 1'b0, 1'b0);
    step("c_s2", L_MY, 2'b10, 1'b0);

    // Reprogram while in side green
    step("d_s4", L_SG, 2'b00, 1'b0);
    tif.Prog_Sync = 1'b1;
    tick();
    tif.Prog_Sync = 1'b0;
    chk_out("d_prog", L_MG, 2'b00, 1'b0, 1'b1);
    tick();
    chk_out("d_prog2", L_MG, 2'b00, 1'b0, 1'b0);
    step("d_s1", L_MG, 2'b01, 1'b0);
    tif.Prog_Sync = 1'b1;
    tif.expired   = 1'b1;
    tick();
    tif.Prog_Sync = 1'b0;
    tif.expired   = 1'b0;
    chk_out("d_prio", L_MG, 2'b00, 1'b0, 1'b1);
    tick();

    // Reset while walking
    tif.Sensor_Sync = 1'b0;
    tif.WR          = 1'b1;
    step("e_s1", L_MG, 2'b00, 1'b0);
    step("e_s2", L_MY, 2'b10, 1'b0);
    step("e_s3", L_WK, 2'b01, 1'b1);
    tick();
    chk_out("e_dwell", L_WK, 2'b01, 1'b1, 1'b0);
    Reset = 1'b1;
    tick();
    chk_out("e_rst", L_MG, 2'b00, 1'b0, 1'b1);
    Reset = 1'b0;
    tick();
    chk_out("e_rel", L_MG, 2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Main-street / side-street traffic-light controller with a pedestrian walk phase.
- Consumes synchronized side-street sensor, walk-request and reprogram inputs, plus an `expired` pulse from an external interval timer.
- Drives the timer (interval select and start pulse), the seven signal LEDs, and a clear strobe for the external walk-request latch.
- Sits between the input synchronizers/walk latch and the programmable timer block.

Parameters:
- T_BASE, 2'b00, interval code for the base green time
- T_EXT, 2'b01, interval code for the extension/walk time
- T_YEL, 2'b10, interval code for the yellow time

Ports:
- clk  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- Sensor_Sync  input  1  side-street vehicle present (already synchronized)
- WR  input  1  latched walk request
- Prog_Sync  input  1  reprogram pulse (synchronized); restarts the sequence
- expired  input  1  timer expired, one-cycle pulse
- WR_Reset  output  1  clears the external walk-request latch
- interval  output  2  interval select to the timer
- start_timer  output  1  one-cycle timer (re)start pulse
- LEDs  output  7  [6] main R, [5] main Y, [4] main G, [3] side R, [2] side Y, [1] side G, [0] walk

Behaviour:
- Moore FSM; all outputs registered and decoded from state.
- One clock; reset is synchronous and active-high. Ports are named clk and Reset.
- States (interval, LEDs):
  - S0 MAIN_GRN_BASE: T_BASE, 0011000
  - S1 MAIN_GRN_2: interval is T_EXT if Sensor_Sync was 1 on the entry cycle, else T_BASE; LEDs 0011000
  - S2 MAIN_YEL: T_YEL, 0101000
  - S3 WALK: T_EXT, 1001001, WR_Reset=1
  - S4 SIDE_GRN_BASE: T_BASE, 1000010
  - S5 SIDE_GRN_EXT: T_EXT, 1000010
  - S6 SIDE_YEL: T_YEL, 1000100
- Transitions, taken only on a cycle with expired=1:
  - S0->S1
  - S1->S2
  - S2->S3 if WR=1, else S4
  - S3->S4
  - S4->S5 if Sensor_Sync=1, else S6
  - S5->S6
  - S6->S0
- start_timer:
  - Pulses high for exactly the first cycle of every new state, including S0 after reset or Prog_Sync.
  - expired is ignored on any cycle in which start_timer=1.
- WR_Reset is high for every cycle spent in S3 and low elsewhere.
- Reset=1: next state S0, interval=T_BASE, LEDs=0011000, WR_Reset=0, start_timer=1. start_timer stays 1 while Reset is held and remains high for the first cycle after release.
- Prog_Sync=1 (Reset=0): same effect as Reset, from any state, mid-interval included.
- Priority: Reset > Prog_Sync > expired.
- Exactly one red/yellow/green is lit per street in every state. Walk is on only in S3. Both streets are never non-red simultaneously.
- Sensor_Sync and WR are sampled only on the cycle the transition is decided.
- Illegal/unused state encodings recover to S0 with start_timer=1.

Optional Feature:
- Macro: TRAFFIC_SIDE_EXT_EN.
- Defined: S5 exists; S4 goes to S5 when Sensor_Sync=1.
- Undefined: S5 is removed and S4 always goes to S6 on expired, regardless of Sensor_Sync.

Test Plan:
- Reset held 1 cycle, WR=0, Sensor_Sync=0 -> S0: LEDs=0011000, interval=00, start_timer=1 for one cycle after release, WR_Reset=0.
- WR=1, Sensor_Sync=0, pulse expired at each interval -> LEDs sequence 0011000, 0011000 (interval 00), 0101000 (interval 10), 1001001 (interval 01, WR_Reset=1), 1000010 (interval 00), 1000100 (interval 10), 0011000. start_timer pulses once per transition.
- Sensor_Sync=1 from reset, WR=0 -> S1 interval=01; S2 goes directly to S4. With TRAFFIC_SIDE_EXT_EN defined, S4 goes to S5 (interval=01, LEDs=1000010), then S6. With it undefined, S4 goes to S6.
- expired asserted in the same cycle as start_timer -> no state change. Held high two cycles -> exactly one transition.
- Prog_Sync pulsed while in S4 -> next cycle S0, LEDs=0011000, start_timer=1.
- Reset asserted while in S3 -> WR_Reset drops to 0 next cycle, state S0.
